// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile: SCCB responder backed by a 256x8 register file.
// Emits a one-cycle strobe for every register written.
module sccb_slave_regfile #(
  parameter logic [7:0] SLAVE_ID = 8'h60,
  parameter bit ACK_EN = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sio_c,
  input  logic       sio_d_i,
  output logic       sio_d_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       id_mismatch,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic scl, sda, scl_q, sda_q, rise, fall, start, stop;
  logic [7:0] sh, ptr, ptr_inc, rd_byte;
  logic [3:0] cnt;
  logic rw, nack, byte_done, id_ok, oe_n, wr_en, mis;
  logic [7:0] mem [256];
  assign scl = c_sync[SYNC_STAGES-1];
  assign sda = d_sync[SYNC_STAGES-1];
  assign rise = scl & ~scl_q;
  assign fall = ~scl & scl_q;
  assign start = scl & scl_q & sda_q & ~sda;
  assign stop = scl & scl_q & ~sda_q & sda;
  assign byte_done = cnt == 4'd8;
  assign id_ok = sh[7:1] == SLAVE_ID[7:1];
  assign ptr_inc = ptr + 8'd1;
  assign rd_byte = mem[state == RD_NACK ? ptr_inc : ptr];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d_i};
      scl_q <= scl;
      sda_q <= sda;
    end
  end
  always_comb begin
    state_n = state;
    if (start) state_n = ID;
    else if (stop) state_n = IDLE;
    else if (fall)
      case (state)
        ID: if (byte_done) state_n = id_ok ? ID_ACK : IGNORE;
        ID_ACK: state_n = rw ? RDATA : SUB;
        SUB: if (byte_done) state_n = SUB_ACK;
        SUB_ACK, WDATA_ACK: state_n = WDATA;
        WDATA: if (byte_done) state_n = WDATA_ACK;
        RDATA: if (byte_done) state_n = RD_NACK;
        RD_NACK: state_n = nack ? IGNORE : RDATA;
        default: state_n = state;
      endcase
  end
  // Drive decisions are taken on a detected SCL fall so the pad only moves while SCL is low.
  always_comb begin
    oe_n = sio_d_oe;
    wr_en = fall && state == WDATA && byte_done;
    mis = fall && state == ID && byte_done && !id_ok;
    if (start || stop) oe_n = 1'b0;
    else if (fall)
      case (state)
        ID, SUB, WDATA: oe_n = ACK_EN & byte_done & (state != ID || id_ok);
        ID_ACK: oe_n = rw & ~rd_byte[7];
        RDATA: oe_n = ~byte_done & ~sh[6];
        RD_NACK: oe_n = ~nack & ~rd_byte[7];
        default: oe_n = 1'b0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      rw <= 1'b0;
      nack <= 1'b0;
      sio_d_oe <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      id_mismatch <= 1'b0;
      mem <= '{default: 8'h00};
    end else begin
      state <= state_n;
      sio_d_oe <= oe_n;
      wr_valid <= wr_en;
      id_mismatch <= mis;
      if (start || state_n != state) cnt <= '0;
      else if (rise) cnt <= cnt + 4'd1;
      if (rise && (state == ID || state == SUB || state == WDATA)) sh <= {sh[6:0], sda};
      if (rise && state == RD_NACK) nack <= sda;
      if (fall && state == RDATA && !byte_done) sh <= {sh[6:0], 1'b0};
      if (fall && ((state == ID_ACK && rw) || (state == RD_NACK && !nack))) sh <= rd_byte;
      if (fall && state == ID && byte_done) rw <= sh[0];
      if (fall && state == SUB && byte_done) ptr <= sh;
      if (fall && state == RD_NACK && !nack) ptr <= ptr_inc;
      if (wr_en) begin
        mem[ptr] <= sh;
        wr_addr <= ptr;
        wr_data <= sh;
        ptr <= ptr_inc;
      end
    end
  end
endmodule

// File: tb/tb_sccb_slave_regfile.sv
// tb_sccb_slave_regfile: directed SCCB master transactions against the register-file responder.
module tb_sccb_slave_regfile;
  localparam int Q = 6;
  logic clk = 1'b0, rst = 1'b1, sio_c = 1'b1, m_low = 1'b0;
  logic sio_d_i, sio_d_oe, wr_valid, id_mismatch, busy;
  logic [7:0] wr_addr, wr_data, last_addr, last_data, v;
  int passed = 0, fails = 0, total = 0, wv_cnt = 0, mis_cnt = 0, oe_cnt = 0;
  int wv0, mis0, oe0;
  logic k;
  always #5 clk = ~clk;
  assign sio_d_i = ~(m_low | sio_d_oe);
  sccb_slave_regfile dut (
    .clk(clk), .rst(rst), .sio_c(sio_c), .sio_d_i(sio_d_i), .sio_d_oe(sio_d_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .id_mismatch(id_mismatch), .busy(busy)
  );
  always @(posedge clk) begin
    if (wr_valid) begin
      wv_cnt <= wv_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (id_mismatch) mis_cnt <= mis_cnt + 1;
    if (sio_d_oe) oe_cnt <= oe_cnt + 1;
  end
  task automatic q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_start();
    m_low = 1'b0; q(); sio_c = 1'b1; q(); m_low = 1'b1; q(); sio_c = 1'b0; q();
  endtask
  task automatic m_stop();
    sio_c = 1'b0; q(); m_low = 1'b1; q(); sio_c = 1'b1; q(); m_low = 1'b0; q(); q();
  endtask
  task automatic m_bit(input logic b, output logic r);
    sio_c = 1'b0; m_low = ~b; q(); sio_c = 1'b1; q(); r = sio_d_i; q(); sio_c = 1'b0; q();
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, ack);
  endtask
  task automatic read_byte(input logic nk, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(nk, r);
  endtask
  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d);
    logic a_k;
    m_start();
    write_byte(8'h60, a_k); chk("wr_id_ack", a_k, 0);
    write_byte(a, a_k); chk("wr_sub_ack", a_k, 0);
    write_byte(d, a_k); chk("wr_dat_ack", a_k, 0);
    m_stop();
  endtask
  task automatic rd_txn(input logic [7:0] a, output logic [7:0] d);
    logic a_k;
    m_start(); write_byte(8'h60, a_k); write_byte(a, a_k); m_stop();
    m_start(); write_byte(8'h61, a_k); chk("rd_id_ack", a_k, 0);
    read_byte(1'b1, d);
    m_stop();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", sio_d_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_mismatch", id_mismatch, 0);
    chk("rst_busy", busy, 0);
    // single write to 0xFF
    wv0 = wv_cnt;
    m_start();
    chk("busy_after_start", busy, 1);
    write_byte(8'h60, k); chk("w_id_ack", k, 0);
    write_byte(8'hFF, k); chk("w_sub_ack", k, 0);
    write_byte(8'h01, k); chk("w_dat_ack", k, 0);
    m_stop();
    chk("busy_after_stop", busy, 0);
    chk("w_count", wv_cnt - wv0, 1);
    chk("w_addr", last_addr, 8'hFF);
    chk("w_data", last_data, 8'h01);
    rd_txn(8'hFF, v); chk("w_readback", v, 8'h01);
    // read of preloaded 0x0A
    wr_txn(8'h0A, 8'hA5);
    m_start(); write_byte(8'h60, k); write_byte(8'h0A, k); m_stop();
    m_start(); write_byte(8'h61, k); chk("r_id_ack", k, 0);
    read_byte(1'b1, v);
    chk("r_bits", v, 8'hA5);
    chk("r_oe_after_nack", sio_d_oe, 0);
    chk("r_busy_ignore", busy, 1);
    m_stop();
    chk("r_busy_stop", busy, 0);
    // ID mismatch
    wv0 = wv_cnt; mis0 = mis_cnt; oe0 = oe_cnt;
    m_start();
    write_byte(8'h42, k); chk("m_no_ack", k, 1);
    write_byte(8'h10, k); write_byte(8'h55, k);
    m_stop();
    chk("m_pulses", mis_cnt - mis0, 1);
    chk("m_oe_cycles", oe_cnt - oe0, 0);
    chk("m_no_write", wv_cnt - wv0, 0);
    rd_txn(8'h10, v); chk("m_reg10", v, 8'h00);
    // burst with address wrap
    wv0 = wv_cnt;
    m_start();
    write_byte(8'h60, k); write_byte(8'hFE, k);
    write_byte(8'h11, k); chk("b_ack1", k, 0);
    write_byte(8'h22, k); chk("b_ack2", k, 0);
    write_byte(8'h33, k); chk("b_ack3", k, 0);
    m_stop();
    chk("b_count", wv_cnt - wv0, 3);
    chk("b_last_addr", last_addr, 8'h00);
    chk("b_last_data", last_data, 8'h33);
    m_start(); write_byte(8'h60, k); write_byte(8'hFE, k); m_stop();
    m_start(); write_byte(8'h61, k);
    read_byte(1'b0, v); chk("b_regFE", v, 8'h11);
    read_byte(1'b0, v); chk("b_regFF", v, 8'h22);
    read_byte(1'b1, v); chk("b_reg00", v, 8'h33);
    m_stop();
    // STOP after 4 data bits
    wv0 = wv_cnt;
    m_start(); write_byte(8'h60, k); write_byte(8'h20, k);
    for (int i = 0; i < 4; i++) m_bit(1'b1, k);
    m_stop();
    chk("a_no_write", wv_cnt - wv0, 0);
    chk("a_idle", busy, 0);
    rd_txn(8'h20, v); chk("a_reg20", v, 8'h00);
    // repeated START mid-SUB
    wv0 = wv_cnt;
    m_start(); write_byte(8'h60, k);
    for (int i = 0; i < 4; i++) m_bit(1'b0, k);
    m_start();
    write_byte(8'h60, k); chk("rs_id_ack", k, 0);
    write_byte(8'h30, k); chk("rs_sub_ack", k, 0);
    write_byte(8'h77, k); chk("rs_dat_ack", k, 0);
    m_stop();
    chk("rs_count", wv_cnt - wv0, 1);
    chk("rs_addr", last_addr, 8'h30);
    chk("rs_data", last_data, 8'h77);
    // reset during WDATA bit 5
    wv0 = wv_cnt;
    m_start(); write_byte(8'h60, k); write_byte(8'h40, k);
    for (int i = 0; i < 4; i++) m_bit(1'b1, k);
    sio_c = 1'b0; m_low = 1'b0; q(); sio_c = 1'b1; q();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("x_oe", sio_d_oe, 0);
    chk("x_busy", busy, 0);
    chk("x_wr_addr", wr_addr, 0);
    chk("x_wr_data", wr_data, 0);
    sio_c = 1'b0; q();
    m_stop();
    chk("x_no_write", wv_cnt - wv0, 0);
    rd_txn(8'hFF, v); chk("x_regFF_cleared", v, 8'h00);
    rd_txn(8'h0A, v); chk("x_reg0A_cleared", v, 8'h00);
    wr_txn(8'h40, 8'h9C);
    chk("x_new_addr", last_addr, 8'h40);
    chk("x_new_data", last_data, 8'h9C);
    rd_txn(8'h40, v); chk("x_readback", v, 8'h9C);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sccb_slave_regfile.md
Name: sccb_slave_regfile

Overview:
- SCCB responder (slave) paired with the camera SCCB configuration master; it stands in for the OV2640 register bank in simulation and in camera-emulation builds.
- Receives 3-phase write and 2-phase-write + 2-phase-read transactions on sio_c/sio_d, holds a 256x8 register file, and reports every register write on a strobe port.
- Oversamples the bus with clk; clk must be at least 8x the SCL frequency.

Parameters:
- SLAVE_ID, 8'h60, 8-bit write ID; bit 0 is ignored for matching, and ID|1 selects read.
- ACK_EN, 1, 1 = drive the ACK bit low on a matched ID/sub-address/data byte; 0 = never drive during ACK (SCCB don't-care).
- SYNC_STAGES, 2, number of synchroniser flops on sio_c and sio_d_i (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (decided)
- sio_c  in  1  SCCB clock from the master
- sio_d_i  in  1  SCCB data as seen on the pad (pulled up)
- sio_d_oe  out  1  1 = pull sio_d low; 0 = release (open drain)
- wr_valid  out  1  one-cycle pulse when a register is written
- wr_addr  out  8  address of that write
- wr_data  out  8  data of that write
- id_mismatch  out  1  one-cycle pulse when a received ID does not match
- busy  out  1  high from START to STOP

Behaviour:
- Reset values:
  - sio_d_oe=0, wr_valid=0, wr_addr=0, wr_data=0, id_mismatch=0, busy=0.
  - All 256 registers = 8'h00.
  - FSM=IDLE; sub-address pointer = 0.
  - Reset asserted mid-transfer aborts the transfer immediately, with the same values.
- Synchronisation and bus events:
  - sio_c and sio_d_i pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
  - The slave changes sio_d_oe only in the cycle after a detected SCL falling edge.
- START from any state, including a repeated start: go to ID, bit count=0, busy=1, sio_d_oe=0.
- STOP from any state: go to IDLE, busy=0, sio_d_oe=0.
  - A partially received byte is discarded; no write occurs.
- FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK, IGNORE.
- ID:
  - After 8 bits, compare bits [7:1] to SLAVE_ID[7:1].
  - Match with bit0=0 -> ID_ACK then SUB.
  - Match with bit0=1 -> ID_ACK then RDATA.
  - Mismatch -> id_mismatch pulses one cycle, go to IGNORE (no ACK driven, bus ignored until START/STOP).
- ACK bits: on the SCL falling edge after the 8th bit, if ACK_EN=1, sio_d_oe=1. Release it on the next SCL falling edge.
- SUB: the 8 received bits are latched into the pointer, then go to WDATA.
  - A STOP here ends the 2-phase write; the pointer is retained for the following read.
- WDATA: on the SCL falling edge ending the 8th bit:
  - reg[pointer] <= byte; wr_valid=1 for one cycle with wr_addr=pointer, wr_data=byte.
  - pointer <= pointer+1, wrapping 8'hFF->8'h00.
  - Further bytes continue the burst.
- RDATA:
  - Load reg[pointer] into the shift register at the ID_ACK release edge.
  - Drive each bit on the SCL falling edge: sio_d_oe = ~bit.
  - After 8 bits, release and sample the master's 9th bit (RD_NACK).
  - NACK (1) -> IGNORE until STOP.
  - ACK (0) -> pointer+1 (wrapping) and send the next byte.
- A simultaneous external write strobe cannot occur; the register file is written only by the bus.
- wr_valid and id_mismatch never pulse twice for one byte.

Test Plan:
- Write: START, 0x60, 0xFF, 0x01, STOP -> ACK low on all three 9th bits; single wr_valid with wr_addr=0xFF, wr_data=0x01; reg[0xFF]=0x01; busy falls after STOP.
- Read: preload reg[0x0A]=0xA5. START, 0x60, 0x0A, STOP; START, 0x61; master clocks 8 bits then NACK, STOP -> bits observed on sio_d are 1,0,1,0,0,1,0,1; sio_d_oe=0 after the NACK.
- ID mismatch: START, 0x42, 0x10, 0x55, STOP -> id_mismatch pulses once; sio_d_oe stays 0 throughout; no wr_valid; reg[0x10] unchanged.
- Burst wrap: START, 0x60, 0xFE, 0x11, 0x22, 0x33, STOP -> three wr_valid pulses; reg[0xFE]=0x11, reg[0xFF]=0x22, reg[0x00]=0x33.
- Abort: STOP after 4 data bits of WDATA -> no wr_valid, FSM=IDLE. A repeated START mid-SUB -> new ID phase decodes correctly.
- Reset mid-transfer: assert rst for 1 cycle during WDATA bit 5 -> all outputs 0, registers 0x00; the next full write transaction succeeds.
